// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: tracks in-flight destinations after ID and
// produces stall, bubble, whole-pipe freeze and operand forwarding selects.
module pipe_hazard_unit #(
  parameter int RA_W   = 4,
  parameter int STAGES = 3,
  parameter int FWD_EN = 1,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rn,
  input  logic [RA_W-1:0]  id_rm,
  input  logic             id_use_rn,
  input  logic             id_two_src,
  input  logic [RA_W-1:0]  id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             hazard,
  output logic             bubble,
  output logic             freeze_all,
  output logic [SEL_W-1:0] fwd_sel_rn,
  output logic [SEL_W-1:0] fwd_sel_rm,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam bit FWD = (FWD_EN != 0);

  logic [STAGES:1] sb_v;
  logic [STAGES:1] sb_wb;
  logic [STAGES:1] sb_mr;
  logic [RA_W-1:0] sb_dest [1:STAGES];

  logic [STAGES:1] hit_rn;
  logic [STAGES:1] hit_rm;
  logic            raw_hz;
  logic            issue;

  // Lowest set bit index of the hit vector: the youngest producer wins.
  function automatic logic [SEL_W-1:0] youngest(input logic [STAGES:1] hits);
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (hits[k]) sel = SEL_W'(k);
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (&val) res = val;
    else      res = val + 1'b1;
    return res;
  endfunction

  always_comb begin
    hit_rn = '0;
    hit_rm = '0;
    for (int k = 1; k <= STAGES; k++) begin
      hit_rn[k] = id_valid & id_use_rn  & sb_v[k] & sb_wb[k] & (sb_dest[k] == id_rn);
      hit_rm[k] = id_valid & id_two_src & sb_v[k] & sb_wb[k] & (sb_dest[k] == id_rm);
    end
  end

  // In forwarding mode only a load still in EXE cannot be bypassed.
  always_comb begin
    raw_hz     = 1'b0;
    fwd_sel_rn = '0;
    fwd_sel_rm = '0;
    if (FWD) begin
      raw_hz     = sb_mr[1] & (hit_rn[1] | hit_rm[1]);
      fwd_sel_rn = youngest(hit_rn);
      fwd_sel_rm = youngest(hit_rm);
    end else begin
      raw_hz     = (|hit_rn) | (|hit_rm);
    end
  end

  assign freeze_all = ~mem_ready;
  assign hazard     = raw_hz & ~branch_taken;
  assign bubble     = hazard & ~freeze_all;
  assign issue      = id_valid & ~hazard & ~branch_taken;

  // Scoreboard shift: control (valid) bits, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_v <= '0;
    end else if (!freeze_all) begin
      sb_v <= {sb_v[STAGES-1:1], issue};
    end
  end

  // Scoreboard shift: payload fields, qualified by sb_v so no reset needed.
  always_ff @(posedge clk) begin
    if (!freeze_all) begin
      sb_wb      <= {sb_wb[STAGES-1:1], id_wb_en};
      sb_mr      <= {sb_mr[STAGES-1:1], id_mem_r_en};
      sb_dest[1] <= id_dest;
      for (int k = 2; k <= STAGES; k++) begin
        sb_dest[k] <= sb_dest[k-1];
      end
    end
  end

  // Stall counter: counts hazard and memory-wait cycles, clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (hazard | freeze_all) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Randomised and directed bench for pipe_hazard_unit in forwarding, stall-only
// and narrow-counter configurations, checked against a stage-occupancy model.
module tb_pipe_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_use_rn, id_two_src, id_wb_en, id_mem_r_en;
  logic       branch_taken, mem_ready, cnt_clr;
  logic [3:0] id_rn, id_rm, id_dest;

  logic        h  [3];
  logic        b  [3];
  logic        fz [3];
  logic [1:0]  sr [3];
  logic [1:0]  sm [3];
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  pipe_hazard_unit #(.RA_W(4), .STAGES(3), .FWD_EN(1), .SEL_W(2), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_two_src(id_two_src), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .cnt_clr(cnt_clr), .hazard(h[0]), .bubble(b[0]),
    .freeze_all(fz[0]), .fwd_sel_rn(sr[0]), .fwd_sel_rm(sm[0]), .stall_cnt(cnt0));

  pipe_hazard_unit #(.RA_W(4), .STAGES(3), .FWD_EN(0), .SEL_W(2), .CNT_W(16)) u_stl (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_two_src(id_two_src), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .cnt_clr(cnt_clr), .hazard(h[1]), .bubble(b[1]),
    .freeze_all(fz[1]), .fwd_sel_rn(sr[1]), .fwd_sel_rm(sm[1]), .stall_cnt(cnt1));

  pipe_hazard_unit #(.RA_W(4), .STAGES(3), .FWD_EN(1), .SEL_W(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_two_src(id_two_src), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .cnt_clr(cnt_clr), .hazard(h[2]), .bubble(b[2]),
    .freeze_all(fz[2]), .fwd_sel_rn(sr[2]), .fwd_sel_rm(sm[2]), .stall_cnt(cnt2));

  // Model: which instruction occupies EXE, MEM, WB (index 0..2) in each instance.
  typedef struct packed {
    logic       v;
    logic [3:0] dest;
    logic       wb;
    logic       mr;
  } occ_t;

  occ_t occ [3][3];
  int   m_cnt [3];
  int   cnt_max [3] = '{65535, 65535, 3};
  bit   cfg_fwd [3] = '{1'b1, 1'b0, 1'b1};
  int   passes = 0;
  int   fails  = 0;

  function automatic int youngest(input int c, input logic [3:0] src, input logic use_it);
    for (int k = 0; k < 3; k++)
      if (id_valid && use_it && occ[c][k].v && occ[c][k].wb && occ[c][k].dest == src)
        return k + 1;
    return 0;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      m_cnt[c] = 0;
      for (int k = 0; k < 3; k++) occ[c][k] = '0;
    end
  endtask

  task automatic predict(input int c, output logic eh, output logic eb, output logic ef,
                         output int ern, output int erm);
    int   yn, ym;
    logic raw;
    yn = youngest(c, id_rn, id_use_rn);
    ym = youngest(c, id_rm, id_two_src);
    if (cfg_fwd[c]) begin
      raw = occ[c][0].mr && (yn == 1 || ym == 1);
      ern = yn;
      erm = ym;
    end else begin
      raw = (yn != 0) || (ym != 0);
      ern = 0;
      erm = 0;
    end
    eh = raw && !branch_taken;
    eb = eh && mem_ready;
    ef = !mem_ready;
  endtask

  task automatic check(input string tag, input int c, input logic [31:0] obs,
                       input logic [31:0] exp);
    assert (obs === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s dut%0d: observed %0d expected %0d", tag, c, obs, exp);
      $error("check %s dut%0d", tag, c);
    end
  endtask

  task automatic tick();
    logic eh, eb, ef;
    int   ern, erm;
    logic hz_seen [3];
    logic [31:0] cobs;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      predict(c, eh, eb, ef, ern, erm);
      hz_seen[c] = eh;
      cobs = (c == 0) ? 32'(cnt0) : (c == 1) ? 32'(cnt1) : 32'(cnt2);
      check("hazard",     c, 32'(h[c]),  32'(eh));
      check("bubble",     c, 32'(b[c]),  32'(eb));
      check("freeze_all", c, 32'(fz[c]), 32'(ef));
      check("fwd_sel_rn", c, 32'(sr[c]), 32'(ern));
      check("fwd_sel_rm", c, 32'(sm[c]), 32'(erm));
      check("stall_cnt",  c, cobs,       32'(m_cnt[c]));
    end
    @(posedge clk);
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        if (mem_ready) begin
          occ[c][2] = occ[c][1];
          occ[c][1] = occ[c][0];
          if (id_valid && !hz_seen[c] && !branch_taken)
            occ[c][0] = '{v: 1'b1, dest: id_dest, wb: id_wb_en, mr: id_mem_r_en};
          else
            occ[c][0] = '0;
        end
        if (cnt_clr) m_cnt[c] = 0;
        else if ((hz_seen[c] || !mem_ready) && m_cnt[c] < cnt_max[c]) m_cnt[c]++;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] rn, input logic urn,
                       input logic [3:0] rm, input logic urm, input logic [3:0] d,
                       input logic wb, input logic mr, input logic bt,
                       input logic rdy, input logic clr);
    id_valid = v; id_rn = rn; id_use_rn = urn; id_rm = rm; id_two_src = urm;
    id_dest = d; id_wb_en = wb; id_mem_r_en = mr; branch_taken = bt;
    mem_ready = rdy; cnt_clr = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    model_clear();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    model_clear();
    tick();
    rst = 1'b1;
    idle(1);

    // ADD r1 then a reader of r1 twice (EXE then MEM forwarding).
    drive(1, 0, 0, 0, 0, 4'd1, 1, 0, 0, 1, 0); tick();
    drive(1, 4'd1, 1, 0, 0, 4'd5, 1, 0, 0, 1, 0); tick();
    drive(1, 4'd1, 1, 4'd1, 1, 4'd6, 0, 0, 0, 1, 0); tick();
    idle(4);

    // LDR r2 followed by a user of r2.
    drive(1, 0, 0, 0, 0, 4'd2, 1, 1, 0, 1, 0); tick();
    drive(1, 4'd2, 1, 0, 0, 4'd7, 1, 0, 0, 1, 0); tick(); tick();
    idle(4);

    // ADD r3 then SUB reading r3 held in ID until the stall clears.
    drive(1, 0, 0, 0, 0, 4'd3, 1, 0, 0, 1, 0); tick();
    drive(1, 4'd9, 1, 4'd3, 1, 4'd8, 1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) tick();
    idle(4);

    // Load-use coinciding with a taken branch.
    drive(1, 0, 0, 0, 0, 4'd2, 1, 1, 0, 1, 0); tick();
    drive(1, 4'd2, 1, 0, 0, 4'd7, 1, 0, 1, 1, 0); tick();
    drive(1, 4'd2, 1, 0, 0, 4'd7, 1, 0, 0, 1, 0); tick();
    idle(4);

    // r4 reaches MEM, then four memory wait cycles, then counter clear.
    drive(1, 0, 0, 0, 0, 4'd4, 1, 0, 0, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 4'd10, 0, 0, 0, 1, 0); tick();
    drive(1, 4'd4, 1, 0, 0, 4'd11, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    drive(1, 4'd4, 1, 0, 0, 4'd11, 1, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    idle(2);

    // Mid-operation reset with live producers.
    drive(1, 0, 0, 0, 0, 4'd5, 1, 0, 0, 1, 0); tick();
    drive(1, 4'd5, 1, 0, 0, 4'd6, 1, 0, 0, 1, 0);
    pulse_reset();
    tick();

    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0,
            4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) != 0, $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end

endmodule
